// File: rtl/freq_div_arbiter.sv
// Round-robin arbiter that lends one programmable frequency divider to NumReq requesters,
// sequencing load / settle / run and skipping the reload when the divisor is unchanged.
module freq_div_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned Width     = 32,
  parameter int unsigned SettleCyc = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] div_val_i,
  input  logic [NumReq-1:0]       rel_i,
  output logic [NumReq-1:0]       grant_o,
  output logic                    busy_o,
  output logic                    err_zero_o,
  output logic [Width-1:0]        div_din_o,
  output logic                    div_config_o,
  output logic                    div_enable_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  typedef enum logic [1:0] {StIdle, StLoad, StSettle, StRun} state_e;

  state_e              state_q, state_d;
  ptr_t                ptr_q, ptr_d;
  ptr_t                owner_q, owner_d;
  logic [Width-1:0]    cap_div_q, cap_div_d;
  logic [Width-1:0]    last_div_q, last_div_d;
  logic                last_valid_q, last_valid_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                err_zero_q, err_zero_d;
  logic [Width-1:0]    div_din_q, div_din_d;
  logic                div_config_q, div_config_d;
  logic                div_enable_q, div_enable_d;

  logic [Width-1:0]    div_arr [NumReq];
  logic                win_found;
  ptr_t                win_idx;
  ptr_t                cand;
  logic [Width-1:0]    win_div;
  int unsigned         idx;

  for (genvar g = 0; g < NumReq; g++) begin : gen_unpack
    assign div_arr[g] = div_val_i[g*Width +: Width];
  end

  function automatic ptr_t ptr_inc(ptr_t p);
    if (32'(p) == NumReq - 1) return '0;
    return p + ptr_t'(1);
  endfunction

  // First requester at or after ptr_q, wrapping modulo NumReq.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_div   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      cand = ptr_t'(idx);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_div   = div_arr[cand];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cap_div_d    = cap_div_q;
    last_div_d   = last_div_q;
    last_valid_d = last_valid_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    err_zero_d   = 1'b0;
    div_din_d    = div_din_q;
    div_config_d = 1'b0;
    div_enable_d = div_enable_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          if (win_div == '0) begin
            err_zero_d = 1'b1;
            ptr_d      = ptr_inc(win_idx);
          end else begin
            cap_div_d = win_div;
            owner_d   = win_idx;
            div_din_d = win_div;
            if (last_valid_q && (win_div == last_div_q)) begin
              // Divider already holds this divisor: skip reprogramming.
              state_d          = StRun;
              grant_d          = '0;
              grant_d[win_idx] = 1'b1;
              div_enable_d     = 1'b1;
            end else begin
              state_d      = StLoad;
              div_config_d = 1'b1;
              div_enable_d = 1'b0;
            end
          end
        end
      end
      StLoad: begin
        last_div_d   = cap_div_q;
        last_valid_d = 1'b1;
        cnt_d        = 4'(SettleCyc - 1);
        state_d      = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d          = StRun;
          grant_d          = '0;
          grant_d[owner_q] = 1'b1;
          div_enable_d     = 1'b1;
          div_din_d        = cap_div_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRun: begin
        if (rel_i[owner_q] || !req_i[owner_q]) begin
          state_d      = StIdle;
          grant_d      = '0;
          div_enable_d = 1'b0;
          ptr_d        = ptr_inc(owner_q);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      owner_q      <= '0;
      cap_div_q    <= '0;
      last_div_q   <= '0;
      last_valid_q <= 1'b0;
      cnt_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      err_zero_q   <= 1'b0;
      div_din_q    <= '0;
      div_config_q <= 1'b0;
      div_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cap_div_q    <= cap_div_d;
      last_div_q   <= last_div_d;
      last_valid_q <= last_valid_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      err_zero_q   <= err_zero_d;
      div_din_q    <= div_din_d;
      div_config_q <= div_config_d;
      div_enable_q <= div_enable_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign err_zero_o   = err_zero_q;
  assign div_din_o    = div_din_q;
  assign div_config_o = div_config_q;
  assign div_enable_o = div_enable_q;

endmodule

// File: doc/freq_div_arbiter.md
Name: freq_div_arbiter

Overview:
- Shares one programmable frequency divider (inputs: divisor, configure strobe, enable) among NUM_REQ requesters.
- Arbitrates round-robin and captures the winner's divisor.
- Programs the divider: enable low, one-cycle configure strobe, settle window, then enable high.
- Holds the grant until the owner releases. Sits between the calculator's timing consumers and the divider.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, divisor width; must match divider data input
SETTLE_CYC, 2, cycles with enable low after configure strobe, before enable (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  request vector; bit i held high while requester i wants the divided clock
div_val  input  NUM_REQ*WIDTH  requested divisors; slice i = div_val[i*WIDTH +: WIDTH]
rel  input  NUM_REQ  release pulse from the owner
grant  output  NUM_REQ  one-hot; owner bit high only while the divided clock is running for it
busy  output  1  high in every state except IDLE
err_zero  output  1  one-cycle pulse when a zero divisor request is rejected
div_din  output  WIDTH  divisor to the divider data input
div_config  output  1  configure strobe to the divider
div_enable  output  1  run enable to the divider

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset, asserted at any time including mid-operation, forces:
  - state IDLE
  - grant=0, busy=0, err_zero=0, div_config=0, div_enable=0, div_din=0
  - round-robin pointer ptr=0
  - last_valid=0
- All outputs are registered.
- FSM states: IDLE, LOAD, SETTLE, RUN.
- IDLE, arbitration:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
  - The winner's div_val slice is captured into cap_div on that cycle. Later changes to div_val are ignored until the next arbitration.
- IDLE, zero divisor: if cap_div would be 0, stay IDLE, pulse err_zero next cycle, set ptr=winner+1 mod NUM_REQ. A still-held request is rejected again on its next turn.
- IDLE, fast path: if last_valid=1 and cap_div==last_div, go directly to RUN. grant and div_enable rise the next cycle.
- IDLE, normal path: go to LOAD.
- LOAD, exactly one cycle:
  - div_config=1, div_din=cap_div, div_enable=0.
  - Set last_div=cap_div, last_valid=1.
- SETTLE: div_config=0, div_enable=0 for exactly SETTLE_CYC cycles (counter), then RUN.
- RUN:
  - grant[owner]=1, div_enable=1, div_din holds cap_div.
  - Exit when rel[owner]=1 or req[owner]=0. Next cycle: IDLE, grant=0, div_enable=0, ptr=owner+1 mod NUM_REQ.
  - rel or req changes from non-owners are ignored.
- Owner withdrawal in LOAD/SETTLE (req[owner] drops): sequence still completes into RUN. RUN then exits on the following cycle. No grant pulse is suppressed; grant is high for exactly 1 cycle.
- Latency: request seen in IDLE at cycle N.
  - Normal path: div_config high at N+1; grant and div_enable high at N+2+SETTLE_CYC.
  - Fast path: grant at N+1.
- At least one IDLE cycle (div_enable=0) between consecutive grants. The divider output therefore returns low between owners.
- Simultaneous rel and a new req from another requester: release wins; the new request is arbitrated in the following IDLE cycle.
- No divisor arithmetic is done here. The zero check is a WIDTH-bit equality; ptr wraps mod NUM_REQ.

Test Plan:
- Reset mid-SETTLE with req[1]=1, div_val[1]=10:
  - All outputs 0 within the same cycle as reset.
  - After reset release: full LOAD sequence again with div_din=10; last_valid was cleared.
- Single request req[0]=1, div_val[0]=8, SETTLE_CYC=2:
  - div_config=1 and div_din=8 at N+1.
  - div_enable=0 at N+2 and N+3.
  - grant=0001 and div_enable=1 at N+4.
  - rel[0] pulse gives grant=0 next cycle.
- req=1111, all divisors distinct, each owner releases after 5 RUN cycles: grant order 0,1,2,3,0; each grant preceded by a LOAD pulse.
- req[2]=1 with div_val[2]=0:
  - err_zero pulses once per rejection, grant never asserts, div_config never asserts.
  - req[3]=1 with divisor 4 is granted next.
- Fast path: req[1]=1 with divisor 6 granted and released, then re-requested with 6. grant rises one cycle after IDLE, no div_config pulse.
- Owner drops req[0] during SETTLE: grant high for exactly one cycle, then IDLE; div_din=captured value throughout.
